led_matrix_column_driver: RTL and testbench

- Consumer end of the LED-matrix scan path. Takes the 0..4 scan index from the driver counter and produces a one-hot column enable plus the 7-bit row pattern for that column.
- Holds a double-buffered 5x7 frame. The writer side loads the back bank; the banks swap atomically at the frame boundary (index wraps 4->0).
- Sits between the scan counter and the matrix pins.

---
 rtl/led_matrix_column_driver.sv | 138 +++++++++++++
 tb/tb_led_matrix_column_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_matrix_column_driver.sv
// LED-matrix column driver: registered one-hot column enable and row pattern from a double-buffered frame.
// Optional inter-column blanking is enabled by defining LED_MATRIX_BLANKING_EN.
module led_matrix_column_driver #(
    parameter int COLS         = 5,
    parameter int ROWS         = 7,
    parameter int BLANK_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      scan_idx,
    input  logic            wr_en,
    input  logic [2:0]      wr_col,
    input  logic [ROWS-1:0] wr_data,
    input  logic            commit,
    output logic            commit_pending,
    output logic            frame_done,
    output logic [COLS-1:0] col_en,
    output logic [ROWS-1:0] row_data
);

    if (COLS < 1 || COLS > 8 || BLANK_CYCLES < 1 || BLANK_CYCLES > 15) begin : g_bad_param
        $error("led_matrix_column_driver: COLS must be 1..8 and BLANK_CYCLES 1..15");
    end

    localparam logic [3:0] COLS_W   = 4'(COLS);
    localparam logic [2:0] LAST_COL = 3'(COLS - 1);

    logic [ROWS-1:0] bank0_q [COLS];
    logic [ROWS-1:0] bank0_d [COLS];
    logic [ROWS-1:0] bank1_q [COLS];
    logic [ROWS-1:0] bank1_d [COLS];
    logic            disp_sel_q, disp_sel_d;
    logic [2:0]      prev_idx_q, prev_idx_d;
    logic            commit_pending_q, commit_pending_d;
    logic            frame_done_q, frame_done_d;
    logic [COLS-1:0] col_en_q, col_en_d;
    logic [ROWS-1:0] row_data_q, row_data_d;

    logic            idx_valid;
    logic            wr_valid;
    logic            boundary;
    logic            swap;
    logic            rd_sel;
    logic [ROWS-1:0] rd_word;

`ifdef LED_MATRIX_BLANKING_EN
    logic [3:0] blank_cnt_q, blank_cnt_d;
`endif

    always_comb begin
        bank0_d          = bank0_q;
        bank1_d          = bank1_q;
        disp_sel_d       = disp_sel_q;
        commit_pending_d = commit_pending_q;
        col_en_d         = '0;
        row_data_d       = '0;
        rd_word          = '0;

        idx_valid = ({1'b0, scan_idx} < COLS_W);
        wr_valid  = wr_en && ({1'b0, wr_col} < COLS_W);
        boundary  = (prev_idx_q == LAST_COL) && (scan_idx == 3'd0);
        swap      = boundary && (commit_pending_q || commit);
        prev_idx_d   = scan_idx;
        frame_done_d = boundary;

        // The write always targets the pre-swap back bank.
        if (wr_valid) begin
            if (disp_sel_q) bank0_d[wr_col] = wr_data;
            else            bank1_d[wr_col] = wr_data;
        end

        if (swap) begin
            disp_sel_d       = ~disp_sel_q;
            commit_pending_d = 1'b0;
        end else if (commit) begin
            commit_pending_d = 1'b1;
        end

        // On a swap edge the output already reads the new display bank; forward a same-edge write into it.
        rd_sel = disp_sel_d;
        if (idx_valid) begin
            rd_word = rd_sel ? bank1_q[scan_idx] : bank0_q[scan_idx];
            if (wr_valid && (rd_sel != disp_sel_q) && (wr_col == scan_idx)) begin
                rd_word = wr_data;
            end
            col_en_d   = COLS'(1) << scan_idx;
            row_data_d = rd_word;
        end

`ifdef LED_MATRIX_BLANKING_EN
        blank_cnt_d = blank_cnt_q;
        if (idx_valid && (scan_idx != prev_idx_q)) begin
            blank_cnt_d = 4'(BLANK_CYCLES - 1);
            col_en_d    = '0;
        end else if (blank_cnt_q != 4'd0) begin
            blank_cnt_d = blank_cnt_q - 4'd1;
            col_en_d    = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < COLS; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
            disp_sel_q       <= 1'b0;
            prev_idx_q       <= 3'd0;
            commit_pending_q <= 1'b0;
            frame_done_q     <= 1'b0;
            col_en_q         <= '0;
            row_data_q       <= '0;
        end else begin
            bank0_q          <= bank0_d;
            bank1_q          <= bank1_d;
            disp_sel_q       <= disp_sel_d;
            prev_idx_q       <= prev_idx_d;
            commit_pending_q <= commit_pending_d;
            frame_done_q     <= frame_done_d;
            col_en_q         <= col_en_d;
            row_data_q       <= row_data_d;
        end
    end

`ifdef LED_MATRIX_BLANKING_EN
    always_ff @(posedge clk) begin
        if (!reset_n) blank_cnt_q <= 4'd0;
        else          blank_cnt_q <= blank_cnt_d;
    end
`endif

    assign commit_pending = commit_pending_q;
    assign frame_done     = frame_done_q;
    assign col_en         = col_en_q;
    assign row_data       = row_data_q;

endmodule

// File: tb/tb_led_matrix_column_driver.sv
// Self-checking bench for led_matrix_column_driver (default build, blanking disabled).
// Vector table plus hand sequences; expected outputs flow through a scoreboard queue.
module tb_led_matrix_column_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] scan_idx;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [6:0] wr_data;
    logic       commit;
    logic       commit_pending;
    logic       frame_done;
    logic [4:0] col_en;
    logic [6:0] row_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic [2:0] idx;
        logic       we;
        logic [2:0] wcol;
        logic [6:0] wdata;
        logic       cmt;
        logic [4:0] e_col;
        logic [6:0] e_row;
        logic       e_pend;
        logic       e_fd;
    } vec_t;

    typedef struct {
        logic [4:0] col;
        logic [6:0] row;
        logic       pend;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[23];

    led_matrix_column_driver #(.COLS(5), .ROWS(7), .BLANK_CYCLES(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .scan_idx       (scan_idx),
        .wr_en          (wr_en),
        .wr_col         (wr_col),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_done     (frame_done),
        .col_en         (col_en),
        .row_data       (row_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [2:0] i, input logic w, input logic [2:0] wc,
                                input logic [6:0] wd, input logic c, input logic [4:0] ec,
                                input logic [6:0] er, input logic ep, input logic ef);
        vec_t v;
        v.rst_n = r; v.idx = i; v.we = w; v.wcol = wc; v.wdata = wd; v.cmt = c;
        v.e_col = ec; v.e_row = er; v.e_pend = ep; v.e_fd = ef;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        reset_n  = v.rst_n;
        scan_idx = v.idx;
        wr_en    = v.we;
        wr_col   = v.wcol;
        wr_data  = v.wdata;
        commit   = v.cmt;
        e.col = v.e_col; e.row = v.e_row; e.pend = v.e_pend; e.fd = v.e_fd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        if (col_en !== got.col) begin
            errors++;
            $display("FAIL %s col_en: got %b expected %b", name, col_en, got.col);
        end
        checks++;
        if (row_data !== got.row) begin
            errors++;
            $display("FAIL %s row_data: got %h expected %h", name, row_data, got.row);
        end
        checks++;
        if (commit_pending !== got.pend) begin
            errors++;
            $display("FAIL %s commit_pending: got %b expected %b", name, commit_pending, got.pend);
        end
        checks++;
        if (frame_done !== got.fd) begin
            errors++;
            $display("FAIL %s frame_done: got %b expected %b", name, frame_done, got.fd);
        end
    endtask

    initial begin
        // rst, idx, we, wcol, wdata, commit | col_en, row, pend, fd
        vecs[0]  = mk(1, 0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 7'h00, 0, 5'b00010, 7'h00, 0, 0);
        vecs[2]  = mk(1, 2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 0);
        vecs[3]  = mk(1, 3, 0, 0, 7'h00, 0, 5'b01000, 7'h00, 0, 0);
        vecs[4]  = mk(1, 4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 1);
        vecs[6]  = mk(1, 0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 0);
        vecs[7]  = mk(1, 1, 1, 2, 7'h55, 0, 5'b00010, 7'h00, 0, 0);
        vecs[8]  = mk(1, 2, 0, 0, 7'h00, 1, 5'b00100, 7'h00, 1, 0);
        vecs[9]  = mk(1, 3, 0, 0, 7'h00, 0, 5'b01000, 7'h00, 1, 0);
        vecs[10] = mk(1, 4, 0, 0, 7'h00, 1, 5'b10000, 7'h00, 1, 0);
        vecs[11] = mk(1, 0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 1);
        vecs[12] = mk(1, 1, 0, 0, 7'h00, 0, 5'b00010, 7'h00, 0, 0);
        vecs[13] = mk(1, 2, 0, 0, 7'h00, 0, 5'b00100, 7'h55, 0, 0);
        vecs[14] = mk(1, 3, 0, 0, 7'h00, 0, 5'b01000, 7'h00, 0, 0);
        vecs[15] = mk(1, 4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 0);
        vecs[16] = mk(1, 0, 1, 0, 7'h7F, 1, 5'b00001, 7'h7F, 0, 1);
        vecs[17] = mk(1, 1, 0, 0, 7'h00, 0, 5'b00010, 7'h00, 0, 0);
        vecs[18] = mk(1, 2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 0);
        vecs[19] = mk(1, 6, 1, 5, 7'h7F, 0, 5'b00000, 7'h00, 0, 0);
        vecs[20] = mk(1, 7, 0, 0, 7'h00, 0, 5'b00000, 7'h00, 0, 0);
        vecs[21] = mk(1, 0, 0, 0, 7'h00, 0, 5'b00001, 7'h7F, 0, 0);
        vecs[22] = mk(1, 4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 0);

        reset_n = 1'b0; scan_idx = 3'd0; wr_en = 1'b0; wr_col = 3'd0; wr_data = 7'h00; commit = 1'b0;
        apply(mk(0, 3, 1, 1, 7'h2A, 1, 5'b00000, 7'h00, 0, 0), "reset_a");
        apply(mk(0, 0, 0, 0, 7'h00, 0, 5'b00000, 7'h00, 0, 0), "reset_b");

        for (int i = 0; i < 23; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Mid-frame reset with a pending commit and a fresh back-bank write.
        apply(mk(1, 1, 1, 0, 7'h3C, 1, 5'b00010, 7'h00, 1, 0), "pre_rst_commit");
        apply(mk(0, 2, 0, 0, 7'h00, 0, 5'b00000, 7'h00, 0, 0), "mid_rst");
        apply(mk(1, 0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 0), "rescan0");
        apply(mk(1, 1, 0, 0, 7'h00, 0, 5'b00010, 7'h00, 0, 0), "rescan1");
        apply(mk(1, 2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 0), "rescan2");
        apply(mk(1, 3, 0, 0, 7'h00, 0, 5'b01000, 7'h00, 0, 0), "rescan3");
        apply(mk(1, 4, 0, 0, 7'h00, 1, 5'b10000, 7'h00, 1, 0), "rescan4_commit");
        apply(mk(1, 0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 1), "swap_after_rst");
        apply(mk(1, 1, 0, 0, 7'h00, 0, 5'b00010, 7'h00, 0, 0), "bank1_col1");
        apply(mk(1, 2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 0), "bank1_col2");

        // Commit with no boundary: pending holds.
        for (int i = 0; i < 4; i++) begin
            apply(mk(1, 3'(i), 0, 0, 7'h00, (i == 0), 5'(1 << i), 7'h00, 1, 0), $sformatf("hold_pend%0d", i));
        end

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
